writeback_stage: RTL and testbench

- Write side of the Y86-64 register file, plus the read ports used by decode.
- Holds the 15 architectural registers (IDs 0x0-0xE; 0xF = RNONE). Each retiring instruction writes valE to dstE and/or valM to dstM.
- Tracks architectural status and halts further writeback after the first non-AOK instruction. Counts retired instructions.
- Sits at the end of the pipeline. Its valA_o/valB_o feed decode_stage.

---
 rtl/writeback_stage.sv | 115 +++++++++++
 tb/tb_writeback_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Y86-64 register file write side with decode read ports, status tracking and retire count.
// Latency: writes visible next cycle (same cycle via BYPASS); no backpressure, every input is accepted.
module writeback_stage #(
    parameter bit         BYPASS   = 1'b1,
    parameter logic [2:0] STAT_AOK = 3'd1,
    parameter logic [2:0] STAT_HLT = 3'd2,
    parameter logic [2:0] STAT_ADR = 3'd3,
    parameter logic [2:0] STAT_INS = 3'd4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    input  logic [3:0]  icode_i,
    input  logic [2:0]  stat_i,
    input  logic [3:0]  dstE_i,
    input  logic [63:0] valE_i,
    input  logic [3:0]  dstM_i,
    input  logic [63:0] valM_i,
    input  logic [3:0]  srcA_i,
    input  logic [3:0]  srcB_i,
    output logic [63:0] valA_o,
    output logic [63:0] valB_o,
    output logic [2:0]  stat_o,
    output logic        halted_o,
    output logic [63:0] retired_o
);

    localparam logic [3:0] RNONE = 4'hF;

    logic [63:0] regs [0:14];
    logic [2:0]  stat_q;
    logic        halted_q;
    logic [63:0] retired_q;
    logic        commit;
    logic        fault;
    logic [63:0] stored_a;
    logic [63:0] stored_b;

    // icode and the non-AOK codes carry no behaviour here; any non-AOK stat halts.
    logic unused_bits;
    assign unused_bits = ^{icode_i, STAT_HLT, STAT_ADR, STAT_INS};

    assign commit = valid_i && !halted_q && (stat_i == STAT_AOK);
    assign fault  = valid_i && !halted_q && (stat_i != STAT_AOK);

    // valM takes priority so popq %rsp leaves the popped value in %rsp.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < 15; i++) begin
                if (dstM_i == 4'(i)) begin
                    regs[i] <= valM_i;
                end else if (dstE_i == 4'(i)) begin
                    regs[i] <= valE_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat_q    <= STAT_AOK;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else if (commit) begin
            retired_q <= retired_q + 64'd1;
        end else if (fault) begin
            stat_q   <= stat_i;
            halted_q <= 1'b1;
        end
    end

    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int i = 0; i < 15; i++) begin
            if (srcA_i == 4'(i)) begin
                stored_a = regs[i];
            end
            if (srcB_i == 4'(i)) begin
                stored_b = regs[i];
            end
        end
    end

    // RNONE never matches a write, so it always reads as zero.
    always_comb begin
        valA_o = stored_a;
        valB_o = stored_b;
        if (BYPASS && commit) begin
            if (srcA_i != RNONE) begin
                if (srcA_i == dstM_i) begin
                    valA_o = valM_i;
                end else if (srcA_i == dstE_i) begin
                    valA_o = valE_i;
                end
            end
            if (srcB_i != RNONE) begin
                if (srcB_i == dstM_i) begin
                    valB_o = valM_i;
                end else if (srcB_i == dstE_i) begin
                    valB_o = valE_i;
                end
            end
        end
    end

    assign stat_o    = stat_q;
    assign halted_o  = halted_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, async-reset sequences, randomized run against a reference model.
module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [3:0]  dst_e;
    logic [63:0] val_e;
    logic [3:0]  dst_m;
    logic [63:0] val_m;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [2:0]  stat_out;
    logic        halted;
    logic [63:0] retired;

    int checks = 0;
    int errors = 0;

    writeback_stage dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .valid_i   (valid),
        .icode_i   (icode),
        .stat_i    (stat),
        .dstE_i    (dst_e),
        .valE_i    (val_e),
        .dstM_i    (dst_m),
        .valM_i    (val_m),
        .srcA_i    (src_a),
        .srcB_i    (src_b),
        .valA_o    (val_a),
        .valB_o    (val_b),
        .stat_o    (stat_out),
        .halted_o  (halted),
        .retired_o (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  s;
        logic [3:0]  de;
        logic [63:0] ve;
        logic [3:0]  dm;
        logic [63:0] vm;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        logic [2:0]  exp_stat;
        logic        exp_halt;
        logic [63:0] exp_ret;
    } vec_t;

    vec_t tbl [9];

    // Reference model: architectural registers, status and retire count.
    logic [63:0] m_reg [15];
    logic        m_halt;
    logic [2:0]  m_stat;
    logic [63:0] m_ret;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm, input logic [3:0] sa, input logic [3:0] sb);
        valid = v;
        icode = 4'h3;
        stat  = s;
        dst_e = de;
        val_e = ve;
        dst_m = dm;
        val_m = vm;
        src_a = sa;
        src_b = sb;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_reg[i] = '0;
        m_halt = 1'b0;
        m_stat = 3'd1;
        m_ret  = '0;
    endtask

    function automatic logic [63:0] model_read(input logic [3:0] src, input logic wr);
        if (src == 4'hF) return 64'd0;
        if (wr && src == dst_m) return val_m;
        if (wr && src == dst_e) return val_e;
        return m_reg[src];
    endfunction

    task automatic check_state(input string tag, input logic [2:0] es, input logic eh, input logic [63:0] er);
        check({tag, ".stat"}, 64'(stat_out), 64'(es));
        check({tag, ".halted"}, 64'(halted), 64'(eh));
        check({tag, ".retired"}, retired, er);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0, 4'h1, 4'h2);

        //            v  s   dE    valE     dM    valM     sA    sB    expA      expB      st  h  ret
        tbl[0] = '{1'b0, 3'd1, 4'hF, 64'h0,    4'hF, 64'h0,    4'h1, 4'h2, 64'h0,    64'h0,    3'd1, 1'b0, 64'd0};
        tbl[1] = '{1'b1, 3'd1, 4'h1, 64'h1111, 4'h2, 64'h2222, 4'h1, 4'h2, 64'h1111, 64'h2222, 3'd1, 1'b0, 64'd1};
        tbl[2] = '{1'b0, 3'd1, 4'hF, 64'h0,    4'hF, 64'h0,    4'h1, 4'h2, 64'h1111, 64'h2222, 3'd1, 1'b0, 64'd1};
        tbl[3] = '{1'b1, 3'd1, 4'h4, 64'h100,  4'h4, 64'h200,  4'h4, 4'h1, 64'h200,  64'h1111, 3'd1, 1'b0, 64'd2};
        tbl[4] = '{1'b0, 3'd1, 4'h3, 64'hDEAD, 4'hF, 64'h0,    4'h3, 4'h4, 64'h0,    64'h200,  3'd1, 1'b0, 64'd2};
        tbl[5] = '{1'b1, 3'd1, 4'hF, 64'h9,    4'hF, 64'h9,    4'h3, 4'hF, 64'h0,    64'h0,    3'd1, 1'b0, 64'd3};
        tbl[6] = '{1'b1, 3'd2, 4'h5, 64'h55,   4'hF, 64'h0,    4'h5, 4'h4, 64'h0,    64'h200,  3'd2, 1'b1, 64'd3};
        tbl[7] = '{1'b1, 3'd1, 4'h5, 64'h77,   4'hF, 64'h0,    4'h5, 4'h1, 64'h0,    64'h1111, 3'd2, 1'b1, 64'd3};
        tbl[8] = '{1'b1, 3'd3, 4'h5, 64'h88,   4'h5, 64'h99,   4'h5, 4'h3, 64'h0,    64'h0,    3'd2, 1'b1, 64'd3};

        #12;
        check("reset.valA", val_a, 64'd0);
        check("reset.valB", val_b, 64'd0);
        check_state("reset", 3'd1, 1'b0, 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            drive(tbl[k].v, tbl[k].s, tbl[k].de, tbl[k].ve, tbl[k].dm, tbl[k].vm, tbl[k].sa, tbl[k].sb);
            #1;
            check($sformatf("vec%0d.valA", k), val_a, tbl[k].exp_a);
            check($sformatf("vec%0d.valB", k), val_b, tbl[k].exp_b);
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", k), tbl[k].exp_stat, tbl[k].exp_halt, tbl[k].exp_ret);
        end

        // Async reset between edges while halted.
        @(negedge clk);
        drive(1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0, 4'h4, 4'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.valA", val_a, 64'd0);
        check("arst.valB", val_b, 64'd0);
        check_state("arst", 3'd1, 1'b0, 64'd0);

        // A commit presented while reset is held is discarded.
        drive(1'b1, 3'd1, 4'h6, 64'h66, 4'h7, 64'h67, 4'h6, 4'h7);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0, 4'h6, 4'h7);
        #1;
        check("rstwr.valA", val_a, 64'd0);
        check("rstwr.valB", val_b, 64'd0);
        check_state("rstwr", 3'd1, 1'b0, 64'd0);

        // Randomized run against the model, with periodic async resets.
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            logic        v;
            logic [2:0]  s;
            logic [3:0]  de;
            logic [3:0]  dm;
            logic        wr;
            @(negedge clk);
            if (n % 300 == 299) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_state("rnd.arst", m_stat, m_halt, m_ret);
                rst_n = 1'b1;
            end
            v  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 79) == 0) ? 3'($urandom_range(2, 7)) : 3'd1;
            de = 4'($urandom_range(0, 15));
            dm = ($urandom_range(0, 5) == 0) ? de : 4'($urandom_range(0, 15));
            drive(v, s, de, {$urandom, $urandom}, dm, {$urandom, $urandom},
                  ($urandom_range(0, 2) == 0) ? dm : 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0) ? de : 4'($urandom_range(0, 15)));
            wr = v && !m_halt && (s == 3'd1);
            #1;
            check("rnd.valA", val_a, model_read(src_a, wr));
            check("rnd.valB", val_b, model_read(src_b, wr));
            @(posedge clk);
            if (wr) begin
                if (dst_e != 4'hF) m_reg[dst_e] = val_e;
                if (dst_m != 4'hF) m_reg[dst_m] = val_m;
                m_ret = m_ret + 64'd1;
            end else if (v && !m_halt) begin
                m_halt = 1'b1;
                m_stat = s;
            end
            #1;
            check_state("rnd", m_stat, m_halt, m_ret);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
